// File: rtl/aes_pkg.sv
// Shared types and constants for the AES core scheduler.
// Word/block widths, state encoding and core timeout.
package aes_pkg;

  localparam int WORD_W      = 32;
  localparam int BLK_W       = 128;
  localparam int NWORD       = BLK_W / WORD_W;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    COLLECT,
    RESP
  } state_t;

  typedef logic [NWORD-1:0][WORD_W-1:0] blk_t;

endpackage

// File: rtl/aes_sched_if.sv
// Requester-side bus of the AES scheduler.
// Two requesters share one request/grant/response bundle.
interface aes_sched_if;
  import aes_pkg::*;

  logic [1:0] req;
  blk_t       key0;
  blk_t       key1;
  blk_t       text0;
  blk_t       text1;
  logic [1:0] gnt;
  logic [1:0] rsp_valid;
  blk_t       rsp_data;
  logic [1:0] rsp_ready;

  modport master (
    output req, key0, key1, text0, text1,
    output rsp_ready,
    input  gnt, rsp_valid, rsp_data
  );

  modport slave (
    input  req, key0, key1, text0, text1,
    input  rsp_ready,
    output gnt, rsp_valid, rsp_data
  );

endinterface

// File: rtl/aes_rr_arb.sv
// Two-way round-robin arbiter.
// Combinational grant, last-grant pointer register.
module aes_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_sel,
  output logic [1:0] gnt
);

  logic ptr;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = ptr ? 2'b01 : 2'b10;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer holds the last served requester; 1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b1;
    end else if (upd) begin
      ptr <= upd_sel;
    end
  end

endmodule

// File: rtl/aes_sched.sv
// AES core scheduler: arbitrates two requesters, streams
// key/text into a 32-bit core and collects the 128-bit result.
module aes_sched
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  aes_sched_if.slave        bus,
  output logic              core_ld,
  output logic [WORD_W-1:0] core_key,
  output logic [WORD_W-1:0] core_text,
  input  logic              core_done,
  input  logic [WORD_W-1:0] core_text_out,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t     state;
  state_t     state_n;
  logic       gsel;
  blk_t       key_q;
  blk_t       text_q;
  blk_t       words;
  logic [1:0] widx;
  logic [7:0] cnt;
  logic [1:0] arb_gnt;
  logic       arb_upd;

  aes_rr_arb u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req),
    .upd     (arb_upd),
    .upd_sel (gsel),
    .gnt     (arb_gnt)
  );

  assign busy         = (state != IDLE);
  assign bus.rsp_data = words;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_n       = state;
    bus.gnt       = 2'b00;
    bus.rsp_valid = 2'b00;
    core_ld       = 1'b0;
    core_key      = '0;
    core_text     = '0;
    arb_upd       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.gnt = arb_gnt;
        if (|bus.req) state_n = LOAD;
      end
      LOAD: begin
        core_ld   = 1'b1;
        core_key  = key_q[~widx];
        core_text = text_q[~widx];
        if (widx == 2'd3) state_n = WAIT;
      end
      WAIT: begin
        if (core_done) state_n = COLLECT;
        else if (cnt == TO_LAST) state_n = IDLE;
      end
      COLLECT: begin
        if (core_done && widx == 2'd3) state_n = RESP;
      end
      RESP: begin
        bus.rsp_valid[gsel] = 1'b1;
        if (bus.rsp_ready[gsel]) begin
          arb_upd = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, word streaming, timeout count, result collection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gsel        <= 1'b0;
      key_q       <= '0;
      text_q      <= '0;
      words       <= '0;
      widx        <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            gsel        <= arb_gnt[1];
            key_q       <= arb_gnt[1] ? bus.key1 : bus.key0;
            text_q      <= arb_gnt[1] ? bus.text1 : bus.text0;
            widx        <= '0;
            timeout_err <= 1'b0;
          end
        end
        LOAD: begin
          widx <= widx + 2'd1;
          cnt  <= '0;
        end
        WAIT: begin
          if (core_done) begin
            words[NWORD-1] <= core_text_out;
            widx           <= 2'd1;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        COLLECT: begin
          if (core_done) begin
            words[~widx] <= core_text_out;
            widx         <= widx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sched.sv
// Self-checking bench for aes_sched.
// Behavioural core model plus a response scoreboard.
module tb_aes_sched;
  import aes_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              core_ld;
  logic [WORD_W-1:0] core_key;
  logic [WORD_W-1:0] core_text;
  logic              core_done;
  logic [WORD_W-1:0] core_text_out;
  logic              busy;
  logic              timeout_err;

  aes_sched_if bus ();

  aes_sched dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text     (core_text),
    .core_done     (core_done),
    .core_text_out (core_text_out),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vld;
    blk_t       data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   core_w   = 10;
  int   core_gap = 0;
  blk_t core_res = '0;
  bit   spur     = 1'b0;

  // Core model: after 4 load words, waits core_w cycles, then
  // returns core_res MSW first with core_gap idle cycles between words.
  initial begin : core_model
    int ldn;
    int cnt;
    int phase;
    int oi;
    int gc;
    ldn = 0; cnt = 0; phase = 0; oi = 0; gc = 0;
    core_done = 1'b0;
    core_text_out = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (!rst) begin
        ldn = 0;
        phase = 0;
      end else if (core_ld) begin
        ldn++;
        if (ldn == 4) begin
          ldn = 0; cnt = 0; phase = 1;
        end
      end else if (phase == 1) begin
        cnt++;
        if (core_w != 0 && cnt == core_w) begin
          core_done = 1'b1;
          core_text_out = core_res[3];
          oi = 1; gc = 0; phase = 2;
        end
      end else if (phase == 2) begin
        if (gc < core_gap) begin
          gc++;
        end else begin
          core_done = 1'b1;
          core_text_out = core_res[3-oi];
          oi++; gc = 0;
          if (oi == 4) phase = 0;
        end
      end else if (spur) begin
        core_done = 1'b1;
        core_text_out = 32'hDEAD_BEEF;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input int max, output logic [1:0] g,
                          output int n);
    #1;
    n = 0;
    g = bus.gnt;
    while (g == 2'b00 && n < max) begin
      tick();
      n++;
      g = bus.gnt;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (bus.rsp_valid == 2'b00 && n < max) begin
      tick();
      n++;
    end
    if (bus.rsp_valid == 2'b00) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.gnt, bus.rsp_valid} !== 4'h0) begin
      errors++;
      $display("FAIL rst_hs got %h want 0", {bus.gnt, bus.rsp_valid});
    end
    checks++;
    if (bus.rsp_data !== '0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", bus.rsp_data);
    end
    checks++;
    if ({core_ld, core_key, core_text} !== 65'h0) begin
      errors++;
      $display("FAIL rst_core got %h want 0",
               {core_ld, core_key, core_text});
    end
    checks++;
    if ({busy, timeout_err} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags got %b want 00", {busy, timeout_err});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    blk_t k;
    blk_t t;
    logic [1:0] g;
    int n;
    exp_t e;
    k = 128'h000102030405060708090a0b0c0d0e0f;
    t = 128'h00112233445566778899aabbccddeeff;
    core_res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    core_w = 10;
    core_gap = 0;
    bus.key0 = k;
    bus.text0 = t;
    bus.req = 2'b01;
    sb.push_back('{vld: 2'b01, data: core_res});
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL single_gnt got %b want 01", g);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) bus.req = 2'b00;
      checks++;
      if ({core_ld, core_key, core_text} !== {1'b1, k[3-i], t[3-i]}) begin
        errors++;
        $display("FAIL single_ld%0d got %h want %h", i,
                 {core_ld, core_key, core_text}, {1'b1, k[3-i], t[3-i]});
      end
    end
    tick();
    checks++;
    if ({core_ld, core_key, core_text} !== 65'h0) begin
      errors++;
      $display("FAIL single_ld_end got %h want 0",
               {core_ld, core_key, core_text});
    end
    wait_valid(40, n);
    checks++;
    if (n + 5 !== 18) begin
      errors++;
      $display("FAIL single_lat got %0d want 18", n + 5);
    end
    e = sb.pop_front();
    checks++;
    if (bus.rsp_valid !== e.vld) begin
      errors++;
      $display("FAIL single_vld got %b want %b", bus.rsp_valid, e.vld);
    end
    checks++;
    if (bus.rsp_data !== e.data) begin
      errors++;
      $display("FAIL single_data got %h want %h", bus.rsp_data, e.data);
    end
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    checks++;
    if ({busy, bus.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL single_idle got %b want 000", {busy, bus.rsp_valid});
    end
  endtask

  task automatic test_rr();
    logic [1:0] ord [3];
    logic [1:0] g;
    int n;
    exp_t e;
    ord = '{2'b01, 2'b10, 2'b01};
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    core_w = 3;
    core_gap = 0;
    bus.key0 = {4{32'h0a0a_0a0a}};
    bus.text0 = {4{32'h0b0b_0b0b}};
    bus.key1 = {4{32'h1a1a_1a1a}};
    bus.text1 = {4{32'h1b1b_1b1b}};
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(10, g, n);
      checks++;
      if (g !== ord[i]) begin
        errors++;
        $display("FAIL rr_gnt%0d got %b want %b", i, g, ord[i]);
      end
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL rr_regrant%0d got %0d want 0", i, n);
      end
      core_res = {4{32'h5000_0000 + 32'(i)}};
      sb.push_back('{vld: ord[i], data: core_res});
      tick();
      bus.req = bus.req & ~ord[i];
      wait_valid(40, n);
      e = sb.pop_front();
      checks++;
      if (bus.rsp_valid !== e.vld) begin
        errors++;
        $display("FAIL rr_vld%0d got %b want %b", i, bus.rsp_valid, e.vld);
      end
      checks++;
      if (bus.rsp_data !== e.data) begin
        errors++;
        $display("FAIL rr_data%0d got %h want %h", i, bus.rsp_data, e.data);
      end
      bus.rsp_ready = e.vld;
      tick();
      bus.rsp_ready = 2'b00;
      if (i < 2) bus.req = bus.req | ord[i];
      else bus.req = 2'b00;
    end
  endtask

  task automatic test_timeout();
    logic [1:0] g;
    int n;
    bit bad;
    exp_t e;
    core_w = 0;
    bus.req = 2'b01;
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL to_gnt got %b want 01", g);
    end
    bad = 1'b0;
    for (int c = 1; c <= 68; c++) begin
      tick();
      if (c == 1) bus.req = 2'b00;
      if (bus.rsp_valid !== 2'b00) bad = 1'b1;
    end
    checks++;
    if ({timeout_err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL to_early got %b want 01", {timeout_err, busy});
    end
    tick();
    checks++;
    if ({timeout_err, busy, bus.rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL to_set got %b want 1000",
               {timeout_err, busy, bus.rsp_valid});
    end
    repeat (3) tick();
    checks++;
    if ({timeout_err, busy, bad} !== 3'b100) begin
      errors++;
      $display("FAIL to_sticky got %b want 100", {timeout_err, busy, bad});
    end
    core_w = 5;
    core_res = 128'hfeed_0001_feed_0002_feed_0003_feed_0004;
    bus.req = 2'b10;
    sb.push_back('{vld: 2'b10, data: core_res});
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b10) begin
      errors++;
      $display("FAIL to_gnt2 got %b want 10", g);
    end
    tick();
    bus.req = 2'b00;
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear got %b want 0", timeout_err);
    end
    wait_valid(40, n);
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {e.vld, e.data}) begin
      errors++;
      $display("FAIL to_rsp got %h want %h",
               {bus.rsp_valid, bus.rsp_data}, {e.vld, e.data});
    end
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_gaps();
    logic [1:0] g;
    int n;
    exp_t e;
    core_w = 7;
    core_gap = 2;
    core_res = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    bus.key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    bus.text1 = 128'h3243f6a8885a308d313198a2e0370734;
    bus.req = 2'b10;
    sb.push_back('{vld: 2'b10, data: core_res});
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b10) begin
      errors++;
      $display("FAIL gap_gnt got %b want 10", g);
    end
    tick();
    bus.req = 2'b00;
    wait_valid(60, n);
    checks++;
    if (n + 1 !== 21) begin
      errors++;
      $display("FAIL gap_lat got %0d want 21", n + 1);
    end
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {e.vld, e.data}) begin
      errors++;
      $display("FAIL gap_rsp got %h want %h",
               {bus.rsp_valid, bus.rsp_data}, {e.vld, e.data});
    end
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    core_gap = 0;
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    int n;
    exp_t e;
    spur = 1'b1;
    core_w = 4;
    core_res = 128'haaaa_0001_bbbb_0002_cccc_0003_dddd_0004;
    bus.req = 2'b01;
    sb.push_back('{vld: 2'b01, data: core_res});
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b01) begin
      errors++;
      $display("FAIL bp_gnt got %b want 01", g);
    end
    tick();
    bus.req = 2'b00;
    wait_valid(40, n);
    checks++;
    if (n + 1 !== 12) begin
      errors++;
      $display("FAIL bp_lat got %0d want 12", n + 1);
    end
    e = sb.pop_front();
    bus.req = 2'b10;
    bus.rsp_ready = 2'b10;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if ({bus.rsp_valid, bus.gnt} !== {e.vld, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d got %b want %b", c,
                 {bus.rsp_valid, bus.gnt}, {e.vld, 2'b00});
      end
      checks++;
      if (bus.rsp_data !== e.data) begin
        errors++;
        $display("FAIL bp_data%0d got %h want %h", c, bus.rsp_data, e.data);
      end
    end
    bus.rsp_ready = 2'b01;
    tick();
    bus.rsp_ready = 2'b00;
    checks++;
    if ({busy, bus.rsp_valid, bus.gnt} !== 5'b00010) begin
      errors++;
      $display("FAIL bp_release got %b want 00010",
               {busy, bus.rsp_valid, bus.gnt});
    end
    core_res = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    sb.push_back('{vld: 2'b10, data: core_res});
    tick();
    bus.req = 2'b00;
    wait_valid(40, n);
    e = sb.pop_front();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data} !== {e.vld, e.data}) begin
      errors++;
      $display("FAIL bp_rsp2 got %h want %h",
               {bus.rsp_valid, bus.rsp_data}, {e.vld, e.data});
    end
    bus.rsp_ready = 2'b10;
    tick();
    bus.rsp_ready = 2'b00;
    spur = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [1:0] g;
    int n;
    bit bad;
    core_w = 5;
    core_res = 128'h9999_0000_9999_0000_9999_0000_9999_0000;
    bus.key0 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    bus.req = 2'b01;
    wait_gnt(10, g, n);
    tick();
    bus.req = 2'b00;
    tick();
    tick();
    checks++;
    if ({core_ld, core_key} !== {1'b1, 32'h0706_0504}) begin
      errors++;
      $display("FAIL ar_ld2 got %h want %h", {core_ld, core_key},
               {1'b1, 32'h0706_0504});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({core_ld, core_key, core_text} !== 65'h0) begin
      errors++;
      $display("FAIL ar_core got %h want 0",
               {core_ld, core_key, core_text});
    end
    checks++;
    if ({busy, timeout_err, bus.gnt, bus.rsp_valid} !== 6'h0) begin
      errors++;
      $display("FAIL ar_flags got %b want 000000",
               {busy, timeout_err, bus.gnt, bus.rsp_valid});
    end
    checks++;
    if (bus.rsp_data !== '0) begin
      errors++;
      $display("FAIL ar_data got %h want 0", bus.rsp_data);
    end
    repeat (2) tick();
    rst = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if ({busy, core_ld, bus.gnt, bus.rsp_valid} !== 6'h0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle got %b want 0", bad);
    end
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_empty got %0d want 0", sb.size());
    end
  endtask

  initial begin
    bus.req = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.key0 = '0;
    bus.key1 = '0;
    bus.text0 = '0;
    bus.text1 = '0;
    test_reset();
    test_single();
    test_rr();
    test_timeout();
    test_gaps();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_sched.md
AES_SCHED -- requirements
Module: aes_sched

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert.
REQ-003 req  input  2  per-requester request; bit i held high until gnt[i].
REQ-004 key0, key1  input  128  requester key, stable while req[i] high.
REQ-005 text0, text1  input  128  requester plaintext, stable while req[i] high.
REQ-006 gnt  output  2  one-cycle pulse; operands of requester i captured.
REQ-007 rsp_valid  output  2  result ready for requester i, one-hot.
REQ-008 rsp_data  output  128  result, valid while any rsp_valid bit is high.
REQ-009 rsp_ready  input  2  requester i accepts the result.
REQ-010 core_ld  output  1  core load strobe.
REQ-011 core_key, core_text  output  32  core word inputs.
REQ-012 core_done  input  1  core output word valid.
REQ-013 core_text_out  input  32  core output word.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 timeout_err  output  1  sticky; set on core timeout, cleared on the next gnt.

Function
REQ-016 FSM states: IDLE, LOAD, WAIT, COLLECT, RESP.
REQ-017 IDLE with any req high: arbitrate, pulse gnt, capture key and text into 128-bit registers, go to LOAD next cycle.
REQ-018 Arbitration: round-robin via a last-grant pointer, reset value 1, so requester 0 wins first. On a tie the non-last requester wins. A single requester always wins.
REQ-019 LOAD lasts exactly 4 cycles with core_ld=1. Word index 0..3 drives bits [127:96], [95:64], [63:32], [31:0] of key and text on core_key and core_text. After word 3, go to WAIT.
REQ-020 Outside LOAD: core_ld=0, core_key=0, core_text=0.
REQ-021 WAIT counts cycles in an 8-bit counter. On core_done=1, capture core_text_out as word 0 and go to COLLECT.
REQ-022 WAIT timeout: if the counter reaches TIMEOUT_CYC (64) with core_done=0, set timeout_err and go to IDLE without asserting rsp_valid.
REQ-023 COLLECT captures words 1..3 on the next three core_done=1 cycles (MSW first), then goes to RESP. Gaps in core_done stall COLLECT and do not lose words.
REQ-024 core_done pulses seen in IDLE, LOAD or RESP are ignored.
REQ-025 RESP holds rsp_valid[granted]=1 and rsp_data stable until rsp_ready[granted]=1. The FSM then returns to IDLE; the grant pointer updates at that point.
REQ-026 rsp_ready on the non-granted bit has no effect.
REQ-027 Earliest re-grant is the cycle after the RESP handshake (one IDLE cycle minimum).
REQ-028 Total latency from gnt to rsp_valid is 4 + W + 4 cycles, where W = WAIT cycles with no other stalls.

Reset
REQ-029 Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, core_ld=0, core_key=0, core_text=0, busy=0, timeout_err=0, counters=0, pointer=1.
REQ-030 Reset asserted mid-operation (any state) aborts immediately; no rsp_valid or gnt follows deassertion unless req is high.

Structure
REQ-031 Shared package aes_pkg holds the state enum type, TIMEOUT_CYC, and the word/block widths (32, 128).
REQ-032 One sub-module, aes_rr_arb: 2-way round-robin arbiter, combinational grant plus pointer register.

Verification
REQ-033 Single request: req=01, key=000102..0F, text=00112233..FF, and a model core returning 69C4E0D8..C55A after W=10 → exactly 4 core_ld cycles with MSW first, rsp_valid=01 on cycle 18 after gnt, rsp_data=69C4E0D86A7B0430D8CDB78070B4C55A.
REQ-034 Simultaneous req=11 from reset → gnt order 01, 10, 01 over three back-to-back transactions.
REQ-035 Core never asserts core_done → timeout_err=1 exactly 64 WAIT cycles after WAIT entry, state returns to IDLE, rsp_valid stays 0. The next gnt clears timeout_err.
REQ-036 core_done gaps of 2 cycles between each output word → rsp_data is still correct and word order is preserved.
REQ-037 rsp_ready held low for 20 cycles → rsp_valid and rsp_data stay stable and no new gnt occurs. Asserting rsp_ready → IDLE the next cycle.
REQ-038 rst driven low during LOAD word 2 → all outputs reach their reset values asynchronously; after release with req=00, the block stays IDLE.
